// File: rtl/fetch_pc_unit.sv
// Fetch PC generator and IF/ID/EXE stage-PC tracker.
// The fetch PC is an 11-bit halfword address. The next PC comes from one of
// four sources: an EXE correction, an ID-stage jump that was not predicted,
// the branch predictor, or the sequential fall-through.
// A saturating counter records how many EXE corrections have occurred.

module fetch_pc_unit #(
    parameter logic [10:0] RESET_PC = 11'h000,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             nrst,
    input  logic             en,
    input  logic             if_is_compressed,
    input  logic             if_prediction,
    input  logic [10:0]      if_PBT,
    input  logic             id_is_jump,
    input  logic             id_jump_in_bht,
    input  logic [10:0]      id_branchtarget,
    input  logic [1:0]       exe_correction,
    input  logic [10:0]      exe_PBT,
    input  logic [10:0]      exe_CNI,
    input  logic             flush,
    output logic [10:0]      if_PC,
    output logic [10:0]      id_PC,
    output logic [10:0]      exe_PC,
    output logic             if_valid,
    output logic             id_valid,
    output logic             exe_valid,
    output logic [1:0]       next_pc_sel,
    output logic [CNT_W-1:0] mispredict_cnt
);

    // BOOT covers the one-cycle read latency of the instruction memory;
    // after that the front end runs freely.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        run;
    logic        redirect_exe;
    logic        redirect_id;
    logic        kill_if;
    logic        kill_id;
    logic [10:0] seq_pc;
    logic [10:0] pc_nxt;

    assign run      = (state == RUN);
    assign if_valid = run;

    // State register. Reset wins over en, and en=0 freezes the FSM.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state <= BOOT;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Next-state logic: BOOT lasts exactly one enabled cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Redirect qualification. A redirect from EXE outranks one from ID, and
    // only RUN can produce either.
    always_comb begin
        redirect_exe = run && exe_correction[1];
        redirect_id  = run && !redirect_exe && id_valid && id_is_jump && !id_jump_in_bht;
        kill_if      = redirect_exe || redirect_id || (run && flush);
        kill_id      = redirect_exe || (run && flush);
    end

    // Next-PC selection by priority. The sequential step wraps at 2^11.
    always_comb begin
        seq_pc      = if_PC + (if_is_compressed ? 11'd1 : 11'd2);
        pc_nxt      = seq_pc;
        next_pc_sel = 2'd0;
        if (run) begin
            if (redirect_exe) begin
                pc_nxt      = exe_correction[0] ? exe_PBT : exe_CNI;
                next_pc_sel = 2'd3;
            end else if (redirect_id) begin
                pc_nxt      = id_branchtarget;
                next_pc_sel = 2'd2;
            end else if (if_valid && if_prediction) begin
                pc_nxt      = if_PBT;
                next_pc_sel = 2'd1;
            end
        end
    end

    // Fetch PC and stage tracking. In BOOT the PC holds. A jump resolved in
    // ID kills only the IF slot, so the jump itself still advances to EXE.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            if_PC     <= RESET_PC;
            id_PC     <= 11'h000;
            exe_PC    <= 11'h000;
            id_valid  <= 1'b0;
            exe_valid <= 1'b0;
        end else if (en && run) begin
            if_PC     <= pc_nxt;
            id_PC     <= if_PC;
            exe_PC    <= id_PC;
            id_valid  <= if_valid && !kill_if;
            exe_valid <= id_valid && !kill_id;
        end
    end

    // Saturating misprediction counter. It never wraps past all-ones.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            mispredict_cnt <= '0;
        end else if (en && redirect_exe && (mispredict_cnt != {CNT_W{1'b1}})) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized
// stimulus, checked against a behavioural model of the fetch front end.

module tb_fetch_pc_unit;

    logic        CLK = 1'b0;
    logic        nrst;
    logic        en;
    logic        if_is_compressed;
    logic        if_prediction;
    logic [10:0] if_PBT;
    logic        id_is_jump;
    logic        id_jump_in_bht;
    logic [10:0] id_branchtarget;
    logic [1:0]  exe_correction;
    logic [10:0] exe_PBT;
    logic [10:0] exe_CNI;
    logic        flush;
    logic [10:0] if_PC;
    logic [10:0] id_PC;
    logic [10:0] exe_PC;
    logic        if_valid;
    logic        id_valid;
    logic        exe_valid;
    logic [1:0]  next_pc_sel;
    logic [15:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_boot;
    logic [10:0] m_if;
    logic [10:0] m_id;
    logic [10:0] m_exe;
    bit          m_idv;
    bit          m_exv;
    int          m_cnt;

    fetch_pc_unit #(.RESET_PC(11'h000), .CNT_W(16)) dut (
        .CLK              (CLK),
        .nrst             (nrst),
        .en               (en),
        .if_is_compressed (if_is_compressed),
        .if_prediction    (if_prediction),
        .if_PBT           (if_PBT),
        .id_is_jump       (id_is_jump),
        .id_jump_in_bht   (id_jump_in_bht),
        .id_branchtarget  (id_branchtarget),
        .exe_correction   (exe_correction),
        .exe_PBT          (exe_PBT),
        .exe_CNI          (exe_CNI),
        .flush            (flush),
        .if_PC            (if_PC),
        .id_PC            (id_PC),
        .exe_PC           (exe_PC),
        .if_valid         (if_valid),
        .id_valid         (id_valid),
        .exe_valid        (exe_valid),
        .next_pc_sel      (next_pc_sel),
        .mispredict_cnt   (mispredict_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit comp, input bit pred, input int pbt,
                                 input bit jmp, input bit inbht, input int btgt,
                                 input int corr, input int epbt, input int ecni, input bit fl);
        en               = e;
        if_is_compressed = comp;
        if_prediction    = pred;
        if_PBT           = 11'(pbt);
        id_is_jump       = jmp;
        id_jump_in_bht   = inbht;
        id_branchtarget  = 11'(btgt);
        exe_correction   = 2'(corr);
        exe_PBT          = 11'(epbt);
        exe_CNI          = 11'(ecni);
        flush            = fl;
    endtask

    task automatic quiet();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Which source the model expects to pick, from the current inputs.
    function automatic int modelSel();
        if (m_boot) return 0;
        if (exe_correction[1]) return 3;
        if (m_idv && id_is_jump && !id_jump_in_bht) return 2;
        if (if_prediction) return 1;
        return 0;
    endfunction

    task automatic checkAll();
        checkOutput("if_PC", 32'(if_PC), 32'(m_if));
        checkOutput("id_PC", 32'(id_PC), 32'(m_id));
        checkOutput("exe_PC", 32'(exe_PC), 32'(m_exe));
        checkOutput("if_valid", 32'(if_valid), 32'(!m_boot));
        checkOutput("id_valid", 32'(id_valid), 32'(m_idv));
        checkOutput("exe_valid", 32'(exe_valid), 32'(m_exv));
        checkOutput("next_pc_sel", 32'(next_pc_sel), 32'(modelSel()));
        checkOutput("mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt));
    endtask

    // One clock: optionally compare at the falling edge, advance the model
    // using the inputs in force for the coming rising edge, then wait past it.
    task automatic stepCycle(input bit doCheck);
        int sel;
        int tgt;
        @(negedge CLK);
        if (doCheck) checkAll();
        if (!nrst) begin
            m_boot = 1; m_if = 11'h000; m_id = 11'h000; m_exe = 11'h000;
            m_idv = 0; m_exv = 0; m_cnt = 0;
        end else if (en) begin
            if (m_boot) begin
                m_boot = 0;
            end else begin
                sel = modelSel();
                case (sel)
                    3: tgt = (exe_correction == 2'b11) ? int'(exe_PBT) : int'(exe_CNI);
                    2: tgt = int'(id_branchtarget);
                    1: tgt = int'(if_PBT);
                    default: tgt = (int'(m_if) + (if_is_compressed ? 1 : 2)) % 2048;
                endcase
                m_exe = m_id;
                m_id  = m_if;
                m_if  = 11'(tgt);
                m_exv = m_idv && !(sel == 3 || flush);
                m_idv = !(sel == 3 || sel == 2 || flush);
                if (sel == 3 && m_cnt < 65535) m_cnt++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        quiet();
        stepCycle(0);
        stepCycle(1);

        // Reset values, then BOOT
        checkOutput("rst_if_PC", 32'(if_PC), 32'h000);
        checkOutput("rst_valid", 32'({if_valid, id_valid, exe_valid}), 32'h0);
        checkOutput("rst_cnt", 32'(mispredict_cnt), 32'h0);
        nrst = 1'b1;
        stepCycle(1);
        checkOutput("boot_hold_pc", 32'(if_PC), 32'h000);
        checkOutput("run_if_valid", 32'(if_valid), 32'h1);
        stepCycle(1);
        checkOutput("seq_32", 32'(if_PC), 32'h002);
        stepCycle(1);
        checkOutput("seq_32b", 32'(if_PC), 32'h004);

        // Predicted jump to 010, compressed then 32-bit
        applyStimulus(1, 0, 1, 'h010, 0, 0, 0, 0, 0, 0, 0);
        stepCycle(1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle(1);
        checkOutput("seq_16", 32'(if_PC), 32'h011);
        quiet();
        stepCycle(1);
        checkOutput("mixed_32", 32'(if_PC), 32'h013);
        checkOutput("id_trails", 32'(id_PC), 32'h011);
        checkOutput("exe_trails", 32'(exe_PC), 32'h010);

        // Wrap at the top of the address space
        applyStimulus(1, 0, 1, 'h7FF, 0, 0, 0, 0, 0, 0, 0);
        stepCycle(1);
        quiet();
        stepCycle(1);
        checkOutput("wrap", 32'(if_PC), 32'h001);

        // EXE correction to CNI kills both younger slots
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2, 0, 'h022, 0);
        stepCycle(1);
        checkOutput("cni_pc", 32'(if_PC), 32'h022);
        checkOutput("cni_kill", 32'({id_valid, exe_valid}), 32'h0);
        checkOutput("cni_cnt", 32'(mispredict_cnt), 32'h1);

        // EXE and ID redirect together: EXE wins
        quiet();
        stepCycle(1);
        applyStimulus(1, 0, 1, 'h050, 1, 0, 'h200, 3, 'h100, 0, 0);
        stepCycle(1);
        checkOutput("exe_beats_id", 32'(if_PC), 32'h100);
        checkOutput("both_kill", 32'({id_valid, exe_valid}), 32'h0);

        // Unpredicted ID jump: the jump still reaches EXE
        quiet();
        stepCycle(1);
        applyStimulus(1, 0, 0, 0, 1, 0, 'h300, 0, 0, 0, 0);
        stepCycle(1);
        checkOutput("id_jump_pc", 32'(if_PC), 32'h300);
        checkOutput("id_jump_valid", 32'({id_valid, exe_valid}), 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycle(1);
        checkOutput("flush_pc", 32'(if_PC), 32'h302);
        checkOutput("flush_kill", 32'({id_valid, exe_valid}), 32'h0);

        // Drive the counter to saturation
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2047),
                          0, 0, 0, $urandom_range(2, 3), $urandom_range(0, 2047),
                          $urandom_range(0, 2047), 0);
            stepCycle(i % 4096 == 0);
        end
        quiet();
        stepCycle(1);
        checkOutput("cnt_saturated", 32'(mispredict_cnt), 32'hFFFF);

        // Hold with en=0 while other inputs move
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, $urandom_range(0, 1), 1, $urandom_range(0, 2047), 1, 0,
                          $urandom_range(0, 2047), 3, $urandom_range(0, 2047), 0, 1);
            stepCycle(1);
        end

        // Reset mid-run, even with en low
        nrst = 1'b0;
        stepCycle(1);
        checkOutput("midrst_pc", 32'(if_PC), 32'h000);
        checkOutput("midrst_valid", 32'({if_valid, id_valid, exe_valid}), 32'h0);
        checkOutput("midrst_cnt", 32'(mispredict_cnt), 32'h0);
        nrst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            nrst = ($urandom_range(0, 39) != 0);
            applyStimulus($urandom_range(0, 4) != 0, $urandom_range(0, 1),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 2047),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                          $urandom_range(0, 2047),
                          ($urandom_range(0, 5) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1),
                          $urandom_range(0, 2047), $urandom_range(0, 2047),
                          $urandom_range(0, 7) == 0);
            stepCycle(1);
        end
        nrst = 1'b1;
        quiet();
        stepCycle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
